pcm_frame_packer: RTL and testbench

Multi-channel PCM frame packer sitting directly downstream of the per-channel decimation chain (CIC → HalfBand1 → HalfBand2 → F_FIR). Captures one 16-bit output sample from every microphone channel on each output-rate strobe, double-buffers the frame, and streams it as a header word plus NCH sample words over a valid/ready interface toward the beamforming/host transport. Dropped frames are counted and made visible through the header frame number.

---
 rtl/pcm_frame_packer_pkg.sv | 15 +
 rtl/pcm_frame_packer_frame_bank.sv | 44 ++++
 rtl/pcm_frame_packer.sv | 179 +++++++++++++++++
 tb/tb_pcm_frame_packer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_frame_packer_pkg.sv
// Shared defaults and read-FSM state encoding for the PCM frame packer.
package pdm_pkg;

    localparam int NCH_DEF  = 20;
    localparam int W_DEF    = 16;
    localparam int OVFW_DEF = 8;
    localparam int CHW_DEF  = (NCH_DEF > 1) ? $clog2(NCH_DEF) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/pcm_frame_packer_frame_bank.sv
// Two-bank frame store: whole-frame write into one bank, single sample/frame-number read.
module frame_bank
    import pdm_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int W   = W_DEF,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wr_en,
    input  logic               i_wr_bank,
    input  logic [NCH*W-1:0]   i_wr_data,
    input  logic [W-1:0]       i_wr_frame,
    input  logic               i_rd_bank,
    input  logic [CHW-1:0]     i_rd_ch,
    output logic [W-1:0]       o_rd_sample,
    output logic [W-1:0]       o_rd_frame
);

    logic [W-1:0] r_smp [2][NCH];
    logic [W-1:0] r_fno [2];

    // Bank storage; a capture overwrites every channel of the selected bank at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                r_fno[b] <= {W{1'b0}};
                for (int c = 0; c < NCH; c++) begin
                    r_smp[b][c] <= {W{1'b0}};
                end
            end
        end else if (i_wr_en) begin
            r_fno[i_wr_bank] <= i_wr_frame;
            for (int c = 0; c < NCH; c++) begin
                r_smp[i_wr_bank][c] <= i_wr_data[c*W +: W];
            end
        end
    end

    assign o_rd_sample = r_smp[i_rd_bank][i_rd_ch];
    assign o_rd_frame  = r_fno[i_rd_bank];

endmodule

// File: rtl/pcm_frame_packer.sv
// Captures one sample per channel per strobe into a double buffer and streams
// each frame as a header word plus NCH samples over valid/ready.
module pcm_frame_packer
    import pdm_pkg::*;
#(
    parameter int NCH  = NCH_DEF,
    parameter int W    = W_DEF,
    parameter int OVFW = OVFW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [NCH*W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic               out_first,
    output logic               out_last,
    output logic [OVFW-1:0]    ovf_cnt,
    output logic               busy
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t            r_state;
    logic [1:0]        r_occ;
    logic              r_wb;
    logic              r_rb;
    logic [CHW-1:0]    r_ch;
    logic [W-1:0]      r_frame_cnt;
    logic [OVFW-1:0]   r_ovf;
    logic              r_out_valid;
    logic [W-1:0]      r_out_data;
    logic              r_out_first;
    logic              r_out_last;
    logic              r_busy;

    logic              w_accept;
    logic              w_last_beat;
    logic              w_release;
    logic              w_capture;
    logic [1:0]        w_occ_next;
    logic              w_rb_next;
    logic [CHW-1:0]    w_rd_ch;
    logic [W-1:0]      w_rd_sample;
    logic [W-1:0]      w_rd_frame;
    logic [W-1:0]      w_hdr_word;

    // Handshake, occupancy and next read address; the header of a frame captured
    // this very cycle is not in the bank yet, so it is taken from the frame counter.
    always_comb begin
        w_accept    = r_out_valid & out_ready;
        w_last_beat = (r_state == DATA) && (r_ch == CHW'(NCH - 1));
        w_release   = w_accept & w_last_beat;
        w_capture   = in_valid & ((r_occ != 2'd2) | w_release);
        w_occ_next  = r_occ + {1'b0, w_capture} - {1'b0, w_release};
        w_rb_next   = w_release ? ~r_rb : r_rb;
        if ((r_state == DATA) && !w_last_beat) begin
            w_rd_ch = r_ch + CHW'(1);
        end else begin
            w_rd_ch = {CHW{1'b0}};
        end
        if (w_capture && (r_wb == w_rb_next)) begin
            w_hdr_word = r_frame_cnt;
        end else begin
            w_hdr_word = w_rd_frame;
        end
    end

    frame_bank #(
        .NCH (NCH),
        .W   (W),
        .CHW (CHW)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_capture),
        .i_wr_bank   (r_wb),
        .i_wr_data   (in_data),
        .i_wr_frame  (r_frame_cnt),
        .i_rd_bank   (w_rb_next),
        .i_rd_ch     (w_rd_ch),
        .o_rd_sample (w_rd_sample),
        .o_rd_frame  (w_rd_frame)
    );

    // Bank pointers, occupancy, frame numbering and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ       <= 2'd0;
            r_wb        <= 1'b0;
            r_rb        <= 1'b0;
            r_frame_cnt <= {W{1'b0}};
            r_ovf       <= {OVFW{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            r_occ  <= w_occ_next;
            r_rb   <= w_rb_next;
            r_busy <= (w_occ_next != 2'd0);
            if (w_capture) begin
                r_wb <= ~r_wb;
            end
            if (in_valid) begin
                r_frame_cnt <= r_frame_cnt + W'(1);
            end
            if (in_valid && !w_capture && (r_ovf != {OVFW{1'b1}})) begin
                r_ovf <= r_ovf + OVFW'(1);
            end
        end
    end

    // Read FSM; output registers only change on an accept, so a stalled word stays put.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ch        <= {CHW{1'b0}};
            r_out_valid <= 1'b0;
            r_out_data  <= {W{1'b0}};
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((r_occ != 2'd0) || w_capture) begin
                        r_state     <= HDR;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_hdr_word;
                        r_out_first <= 1'b1;
                        r_out_last  <= 1'b0;
                    end
                end
                HDR: begin
                    if (w_accept) begin
                        r_state     <= DATA;
                        r_ch        <= {CHW{1'b0}};
                        r_out_data  <= w_rd_sample;
                        r_out_first <= 1'b0;
                        r_out_last  <= (NCH == 1);
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        if (!w_last_beat) begin
                            r_ch       <= w_rd_ch;
                            r_out_data <= w_rd_sample;
                            r_out_last <= (w_rd_ch == CHW'(NCH - 1));
                        end else if (w_occ_next != 2'd0) begin
                            r_state     <= HDR;
                            r_out_data  <= w_hdr_word;
                            r_out_first <= 1'b1;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                            r_out_data  <= {W{1'b0}};
                            r_out_first <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_data  <= {W{1'b0}};
                    r_out_first <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;
    assign ovf_cnt   = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Randomized bench for pcm_frame_packer against a queue-based frame model.
module tb_pcm_frame_packer;
    import pdm_pkg::*;

    localparam int NCH  = NCH_DEF;
    localparam int W    = W_DEF;
    localparam int OVFW = OVFW_DEF;
    localparam int OVF_MAX = (1 << OVFW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic [NCH*W-1:0]   in_data = '0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [W-1:0]       out_data;
    logic               out_first;
    logic               out_last;
    logic [OVFW-1:0]    ovf_cnt;
    logic               busy;

    always #5 clk = ~clk;

    pcm_frame_packer #(.NCH(NCH), .W(W), .OVFW(OVFW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .ovf_cnt   (ovf_cnt),
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: frames held (head is the one on the wire), beat position in head frame.
    logic [W-1:0]     q_fno[$];
    logic [NCH*W-1:0] q_dat[$];
    int               m_pos;
    logic [W-1:0]     m_fcnt;
    int               m_ovf;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NCH*W-1:0] rand_frame();
        logic [NCH*W-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*W +: W] = W'($urandom);
        return r;
    endfunction

    function automatic logic [NCH*W-1:0] ramp_frame();
        logic [NCH*W-1:0] r;
        for (int c = 0; c < NCH; c++) r[c*W +: W] = W'(16'h0100 + c);
        return r;
    endfunction

    task automatic model_reset();
        q_fno.delete();
        q_dat.delete();
        m_pos  = 0;
        m_fcnt = '0;
        m_ovf  = 0;
    endtask

    task automatic check_outputs();
        logic [NCH*W-1:0] d;
        logic [W-1:0]     ew;
        logic             ef;
        logic             el;
        chk_eq("valid", out_valid, q_fno.size() > 0);
        chk_eq("busy", busy, q_fno.size() > 0);
        chk_eq("ovf", ovf_cnt, m_ovf);
        if (q_fno.size() > 0) begin
            if (m_pos == 0) begin
                ew = q_fno[0];
                ef = 1'b1;
                el = 1'b0;
            end else begin
                d  = q_dat[0];
                ew = d[(m_pos-1)*W +: W];
                ef = 1'b0;
                el = (m_pos == NCH);
            end
            chk_eq("data", out_data, ew);
            chk_eq("first", out_first, ef);
            chk_eq("last", out_last, el);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
    task automatic step(input logic iv, input logic [NCH*W-1:0] d, input logic rdy);
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        @(negedge clk);
        check_outputs();
        if (q_fno.size() > 0 && rdy) begin
            if (m_pos == NCH) begin
                void'(q_fno.pop_front());
                void'(q_dat.pop_front());
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (iv) begin
            if (q_fno.size() < 2) begin
                q_fno.push_back(m_fcnt);
                q_dat.push_back(d);
            end else if (m_ovf < OVF_MAX) begin
                m_ovf++;
            end
            m_fcnt = m_fcnt + W'(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string pfx);
        chk_eq({pfx, "_valid"}, out_valid, 0);
        chk_eq({pfx, "_data"}, out_data, 0);
        chk_eq({pfx, "_first"}, out_first, 0);
        chk_eq({pfx, "_last"}, out_last, 0);
        chk_eq({pfx, "_ovf"}, ovf_cnt, 0);
        chk_eq({pfx, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check_zero("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 1000; i++) begin
            if (q_fno.size() == 0) break;
            step(1'b0, '0, 1'b1);
        end
        step(1'b0, '0, 1'b1);
        chk_eq("drain_busy", busy, 0);
    endtask

    initial begin
        model_reset();

        // single frame with channel ramp
        do_reset();
        step(1'b1, ramp_frame(), 1'b1);
        chk_eq("t1_hdr", out_data, 16'h0000);
        chk_eq("t1_first", out_first, 1);
        drain();

        // three strobes while stalled: third dropped
        do_reset();
        for (int i = 0; i < 15; i++) step((i % 5) == 0, rand_frame(), 1'b0);
        chk_eq("t2_ovf", ovf_cnt, 1);
        drain();
        step(1'b1, rand_frame(), 1'b1);
        chk_eq("t2_hdr3", out_data, 16'h0003);
        drain();

        // randomized ready over many frames
        do_reset();
        for (int f = 0; f < 60; f++) begin
            step(1'b1, rand_frame(), ($urandom % 8) != 0);
            for (int k = 0; k < 34; k++) step(1'b0, '0, ($urandom % 8) != 0);
        end
        drain();
        chk_eq("t3_ovf", ovf_cnt, 0);

        // capture in the same cycle as the last beat is accepted while full
        do_reset();
        step(1'b1, rand_frame(), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, rand_frame(), 1'b0);
        step(1'b0, '0, 1'b0);
        for (int i = 0; i < NCH + 3; i++) step(i == NCH, rand_frame(), 1'b1);
        chk_eq("t4_ovf", ovf_cnt, 0);
        drain();

        // asynchronous reset mid-frame
        do_reset();
        step(1'b1, ramp_frame(), 1'b1);
        for (int i = 0; i < 40; i++) begin
            if (m_pos == 8) break;
            step(1'b0, '0, 1'b1);
        end
        chk_eq("t5_ch7", out_data, 16'h0107);
        #2;
        rst = 1'b0;
        #1;
        check_zero("arst");
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b1, rand_frame(), 1'b1);
        chk_eq("t5_hdr", out_data, 16'h0000);
        drain();

        // drop saturation and frame number wrap
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, rand_frame(), 1'b0);
        chk_eq("t6_sat", ovf_cnt, OVF_MAX);
        for (int i = 300; i < 65536; i++) step(1'b1, '0, 1'b0);
        chk_eq("t6_sat_end", ovf_cnt, OVF_MAX);
        drain();
        step(1'b1, rand_frame(), 1'b1);
        chk_eq("t6_wrap_hdr", out_data, 16'h0000);
        chk_eq("t6_wrap_first", out_first, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
